// File: rtl/zero_indices_multi.sv
// zero_indices_multi: streams the positions of target bits (zeros or ones) of a
// W-bit vector, lowest first, up to N indices per valid/ready response beat.

// One extraction lane: picks the lowest set bit of its input, reports its
// index and passes the remaining bits on to the next lane.
module zero_indices_multi_lane #(
  parameter int W  = 32,
  parameter int IW = 5
) (
  input  logic [W-1:0]  rem_in,
  output logic [W-1:0]  rem_out,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [W-1:0] low;

  // Isolate the lowest set bit (two's-complement trick), then drop it.
  assign low     = rem_in & (~rem_in + W'(1));
  assign rem_out = rem_in & ~low;
  assign found   = |rem_in;

  // Encode the one-hot lowest bit; all-zero input yields index 0.
  always_comb begin
    idx = '0;
    for (int b = 0; b < W; b++)
      if (low[b]) idx = b[IW-1:0];
  end
endmodule

module zero_indices_multi #(
  parameter int W = 32,
  parameter int N = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W-1:0]            in_vector,
  input  logic                    in_polarity,
  input  logic                    in_start,
  output logic                    in_busy_r,
  output logic                    resp_valid_r,
  input  logic                    resp_ready,
  output logic [N-1:0]            resp_mask_r,
  output logic [N*$clog2(W)-1:0]  resp_index_r,
  output logic                    resp_last_r
);
  localparam int IW = $clog2(W);

  logic [W-1:0]           work_r;
  logic [N:0][W-1:0]      rem;
  logic [N-1:0]           lane_found;
  logic [N-1:0][IW-1:0]   lane_idx;
  logic                   slot_free;
  logic                   extract;

  // Lanes are chained: each sees what the lower lanes left behind, so the
  // filled lanes are always contiguous from lane 0.
  assign rem[0] = work_r;

  for (genvar i = 0; i < N; i++) begin : g_lane
    zero_indices_multi_lane #(.W(W), .IW(IW)) u_lane (
      .rem_in  (rem[i]),
      .rem_out (rem[i+1]),
      .found   (lane_found[i]),
      .idx     (lane_idx[i])
    );
  end

  assign slot_free = !resp_valid_r || resp_ready;
  assign extract   = in_busy_r && slot_free;

  // Start loads the polarity-normalised vector; each extraction clears the
  // picked bits and registers a beat. A stalled beat freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_r       <= '0;
      in_busy_r    <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_mask_r  <= '0;
      resp_index_r <= '0;
      resp_last_r  <= 1'b0;
    end else begin
      if (extract) begin
        work_r       <= rem[N];
        resp_valid_r <= 1'b1;
        resp_mask_r  <= lane_found;
        resp_index_r <= lane_idx;
        resp_last_r  <= (rem[N] == '0);
        if (rem[N] == '0) in_busy_r <= 1'b0;
      end else if (resp_valid_r && resp_ready) begin
        resp_valid_r <= 1'b0;
      end
      // Start and extract are mutually exclusive (busy gates both).
      if (!in_busy_r && in_start) begin
        work_r    <= in_polarity ? in_vector : ~in_vector;
        in_busy_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_zero_indices_multi.sv
// Bench for zero_indices_multi (W=8, N=2): directed table, hand-written
// stall/overlap/reset sequences, and random traffic against a list model.
module tb_zero_indices_multi;
  localparam int W  = 8;
  localparam int N  = 2;
  localparam int IW = $clog2(W);

  logic              clk, rst;
  logic [W-1:0]      in_vector;
  logic              in_polarity, in_start, in_busy_r;
  logic              resp_valid_r, resp_ready, resp_last_r;
  logic [N-1:0]      resp_mask_r;
  logic [N*IW-1:0]   resp_index_r;

  zero_indices_multi #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_vector(in_vector), .in_polarity(in_polarity),
    .in_start(in_start), .in_busy_r(in_busy_r), .resp_valid_r(resp_valid_r),
    .resp_ready(resp_ready), .resp_mask_r(resp_mask_r),
    .resp_index_r(resp_index_r), .resp_last_r(resp_last_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    vec;
    logic            pol;
    int              nb;
    logic [N-1:0]    m0;
    logic [N*IW-1:0] i0;
  } vec_t;

  typedef struct {
    logic [N-1:0]    mask;
    logic [N*IW-1:0] idx;
    logic            last;
  } beat_t;

  beat_t exp_q[$];
  vec_t  tbl[7];
  int    checks = 0;
  int    failures = 0;
  int    nxfer;
  logic  seen_last;
  logic  prev_stall;
  logic [N-1:0]    prev_mask;
  logic [N*IW-1:0] prev_idx;
  logic            prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: list every target position in ascending order, cut into N-wide beats.
  task automatic push_model(input logic [W-1:0] v, input logic p);
    int hits[$];
    beat_t b;
    for (int i = 0; i < W; i++) if (v[i] == p) hits.push_back(i);
    if (hits.size() == 0) begin
      b.mask = '0; b.idx = '0; b.last = 1'b1;
      exp_q.push_back(b);
    end
    while (hits.size() > 0) begin
      b.mask = '0; b.idx = '0;
      for (int l = 0; l < N && hits.size() > 0; l++) begin
        b.mask[l] = 1'b1;
        b.idx[l*IW +: IW] = IW'(hits.pop_front());
      end
      b.last = (hits.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  // One cycle: sample transfers/holds on the falling edge, return #1 after rise.
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", resp_valid_r, 1);
      chk("hold_mask", resp_mask_r, prev_mask);
      chk("hold_idx", resp_index_r, prev_idx);
      chk("hold_last", resp_last_r, prev_last);
    end
    prev_stall = resp_valid_r && !resp_ready;
    prev_mask = resp_mask_r; prev_idx = resp_index_r; prev_last = resp_last_r;
    if (resp_valid_r && resp_ready) begin
      nxfer++;
      if (resp_last_r) seen_last = 1'b1;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_beat actual=mask %0h idx %0h required=none", resp_mask_r, resp_index_r);
      end else begin
        e = exp_q.pop_front();
        chk("beat_mask", resp_mask_r, e.mask);
        chk("beat_idx", resp_index_r, e.idx);
        chk("beat_last", resp_last_r, e.last);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain_last(input int budget);
    for (int c = 0; c < budget && !seen_last; c++) step();
    chk("saw_last", seen_last, 1);
  endtask

  task automatic run_entry(input vec_t t);
    push_model(t.vec, t.pol);
    in_vector = t.vec; in_polarity = t.pol; in_start = 1'b1; resp_ready = 1'b1;
    nxfer = 0; seen_last = 1'b0;
    step();
    in_start = 1'b0;
    chk("busy_rise", in_busy_r, 1);
    step();
    chk("k2_valid", resp_valid_r, 1);
    chk("k2_mask", resp_mask_r, t.m0);
    chk("k2_idx", resp_index_r, t.i0);
    chk("k2_last", resp_last_r, (t.nb == 1));
    drain_last(20);
    chk("beat_count", nxfer, t.nb);
    chk("idle_busy", in_busy_r, 0);
    chk("idle_valid", resp_valid_r, 0);
  endtask

  initial begin
    logic [W-1:0] v;
    logic p;
    int started, budget;
    tbl[0] = '{8'b1011_0110, 1'b0, 2, 2'b11, {3'd3, 3'd0}};
    tbl[1] = '{8'b1011_0110, 1'b1, 3, 2'b11, {3'd2, 3'd1}};
    tbl[2] = '{8'hFF, 1'b0, 1, 2'b00, 6'd0};
    tbl[3] = '{8'h00, 1'b0, 4, 2'b11, {3'd1, 3'd0}};
    tbl[4] = '{8'h00, 1'b1, 1, 2'b00, 6'd0};
    tbl[5] = '{8'h80, 1'b1, 1, 2'b01, {3'd0, 3'd7}};
    tbl[6] = '{8'hFE, 1'b0, 1, 2'b01, {3'd0, 3'd0}};

    rst = 1'b0; in_vector = '0; in_polarity = 1'b0; in_start = 1'b0; resp_ready = 1'b0;
    prev_stall = 1'b0; nxfer = 0; seen_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", in_busy_r, 0);
    chk("rst_valid", resp_valid_r, 0);
    chk("rst_mask", resp_mask_r, 0);
    chk("rst_idx", resp_index_r, 0);
    chk("rst_last", resp_last_r, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_entry(tbl[i]);

    // Ignored start while busy: only the original two beats appear.
    push_model(8'b1011_0110, 1'b0);
    in_vector = 8'b1011_0110; in_polarity = 1'b0; in_start = 1'b1; resp_ready = 1'b1;
    nxfer = 0; seen_last = 1'b0;
    step();
    in_vector = 8'h00; in_start = 1'b1;
    step();
    in_start = 1'b0;
    drain_last(20);
    repeat (3) begin step(); chk("no_extra_valid", resp_valid_r, 0); end
    chk("ignored_beats", nxfer, 2);

    // Backpressure on the first beat for three cycles.
    push_model(8'h00, 1'b0);
    in_vector = 8'h00; in_polarity = 1'b0; in_start = 1'b1; resp_ready = 1'b0;
    nxfer = 0; seen_last = 1'b0;
    step();
    in_start = 1'b0;
    step();
    repeat (3) begin
      step();
      chk("bp_mask", resp_mask_r, 2'b11);
      chk("bp_idx", resp_index_r, {3'd1, 3'd0});
    end
    resp_ready = 1'b1;
    drain_last(20);
    chk("bp_beats", nxfer, 4);

    // Overlap: next vector accepted while the previous last beat is stalled.
    push_model(8'hF0, 1'b1);
    in_vector = 8'hF0; in_polarity = 1'b1; in_start = 1'b1; resp_ready = 1'b0;
    step();
    in_start = 1'b0;
    step(); step();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("ov_busy_low", in_busy_r, 0);
    chk("ov_last_stalled", resp_valid_r & resp_last_r, 1);
    push_model(8'h01, 1'b1);
    in_vector = 8'h01; in_start = 1'b1;
    step();
    in_start = 1'b0;
    chk("ov_busy_new", in_busy_r, 1);
    chk("ov_held_idx", resp_index_r, {3'd7, 3'd6});
    step();
    chk("ov_held_last", resp_last_r, 1);
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    chk("ov_drained", exp_q.size(), 0);
    step();

    // Random traffic with random backpressure and back-to-back starts.
    started = 0;
    for (budget = 0; budget < 3000 && (started < 40 || exp_q.size() > 0); budget++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      in_start = 1'b0;
      if (started < 40 && !in_busy_r && $urandom_range(0, 1) == 1) begin
        v = W'($urandom);
        p = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) v = p ? 8'h00 : 8'hFF;
        in_vector = v; in_polarity = p; in_start = 1'b1;
        push_model(v, p);
        started++;
      end
      step();
    end
    in_start = 1'b0;
    chk("rand_drained", exp_q.size(), 0);
    resp_ready = 1'b1;
    step(); step();

    // Asynchronous reset with a stalled beat, then a fresh scan.
    in_vector = 8'h00; in_polarity = 1'b0; in_start = 1'b1; resp_ready = 1'b0;
    step();
    in_start = 1'b0;
    step();
    chk("pre_rst_valid", resp_valid_r, 1);
    rst = 1'b0;
    #1;
    chk("arst_busy", in_busy_r, 0);
    chk("arst_valid", resp_valid_r, 0);
    chk("arst_mask", resp_mask_r, 0);
    chk("arst_idx", resp_index_r, 0);
    chk("arst_last", resp_last_r, 0);
    prev_stall = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_entry(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
